eth_tx_framer: RTL and testbench
================================

// Module: eth_tx_framer
// PURPOSE
//  Upstream neighbour of the RMII transmitter. Accepts a raw frame (DA..payload) on a
//  valid/ready byte stream, zero-pads it to the Ethernet minimum and appends the CRC-32 FCS.
//  Writes the result into the TX FIFO, flagging the final FCS byte with EOD for the RMII TX stage.
// PARAMETERS
//  MIN_LEN   60    minimum bytes before FCS; shorter frames are zero-padded
//  MAX_LEN   1514  maximum bytes before FCS; longer frames are truncated and the FCS is stomped
// PORTS
//  REF_CLK       in   1   50MHz clock, shared with the RMII TX domain
//  arst_n        in   1   asynchronous active-low reset
//  in_valid      in   1   input byte valid
//  in_data       in   8   input byte; the first byte is DA[0]
//  in_last       in   1   marks the last input byte of the frame
//  in_ready      out  1   framer accepts the byte when in_valid&in_ready
//  fifo_afull    in   1   TX FIFO almost-full; no write is issued while it is high
//  fifo_wren     out  1   TX FIFO write strobe
//  fifo_din      out  8   TX FIFO data
//  fifo_EOD_in   out  1   end-of-data tag, written together with the last FCS byte
//  frame_count_gray     out 16  frames completed, Gray-coded binary counter
//  oversize_count_gray  out 16  frames truncated at MAX_LEN, Gray-coded
// BEHAVIOUR
//  Reset: state=S_IDLE, in_ready=0, fifo_wren=0, fifo_din=0, fifo_EOD_in=0, byte_cnt=0,
//   crc=32'hFFFFFFFF, both counters=0. A reset mid-frame abandons the frame; the TX FIFO shares arst_n.
//  fifo_wren, fifo_din and fifo_EOD_in are registered: 1 cycle after the accept or pad/FCS decision.
//  in_ready is combinational: (S_IDLE|S_DATA)&~fifo_afull, or S_DRAIN (always 1).
//  CRC: IEEE 802.3 reflected form, poly 32'hEDB88320, init all-ones, updated per byte LSB-first.
//   The FCS is ~crc, sent as byte0=~crc[7:0] .. byte3=~crc[31:24].
//  byte_cnt is 11 bits; it counts bytes written before the FCS and saturates at MAX_LEN.
//  States:
//   S_IDLE : on accept -> write byte, crc update, byte_cnt=1; then S_DATA, or S_PAD/S_FCS if in_last.
//   S_DATA : each accept writes the byte and updates crc, byte_cnt++.
//            If in_last: go to S_PAD when byte_cnt+1<MIN_LEN, else S_FCS.
//            If the accepted byte makes byte_cnt==MAX_LEN without in_last: set stomp, oversize++.
//            Then S_DRAIN.
//   S_DRAIN: accept and discard input (no write, no crc) until in_last, then S_FCS.
//   S_PAD  : when ~fifo_afull write 8'h00 and update crc, byte_cnt++. At byte_cnt==MIN_LEN -> S_FCS.
//   S_FCS  : when ~fifo_afull write FCS byte k (k=0..3, 2-bit index).
//            If stomp, write the inverted FCS byte (the frame then fails CRC at the receiver).
//            At k=3 assert fifo_EOD_in, frame_count++, clear crc/byte_cnt/stomp, go to S_IDLE.
//  Boundaries:
//   - Single-byte frame (in_last on the first byte): 59 pad bytes.
//   - Exactly MIN_LEN: no pad. in_last on byte MAX_LEN: normal, no stomp.
//   - fifo_afull rising mid-frame: hold state with no write; resume with no byte lost or duplicated.
//   - in_valid low mid-frame: wait indefinitely (no timeout).
//   - Counters wrap 16'hFFFF->0.
//   - Undefined state -> S_IDLE with crc, byte_cnt and stomp cleared.
// STRUCTURE
//  Shared package: CRC32_POLY_R=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF,
//   CRC32_RESIDUE=32'hDEBB20E3, ETH_MIN_LEN=60, ETH_MAX_LEN=1514, framer state encodings.
//  Sub-module crc32_d8: combinational next-CRC from (crc_in[31:0], d[7:0]). Reused by the RX checker.
//  Counter outputs use the existing my_bin2gray (WIDTH=16).
// TESTING
//  1 crc32_d8 alone, ASCII "123456789" from init -> ~crc == 32'hCBF43926.
//  2 14-byte frame, in_valid held high -> 60 bytes (46 trailing 8'h00), 4 FCS bytes, EOD only on
//    byte 64; running crc over all 64 bytes == 32'hDEBB20E3; frame_count_gray=16'h0001.
//  3 60-byte and 1514-byte frames -> 64 and 1518 bytes written, no pad, residue OK,
//    oversize count stays 0.
//  4 1600-byte frame -> exactly 1518 writes, FCS inverted (residue != 32'hDEBB20E3),
//    86 bytes drained, oversize_count_gray=16'h0001.
//  5 fifo_afull toggled randomly (30%) plus random in_valid gaps on back-to-back frames
//    -> written stream identical to the no-stall golden model; EOD count equals frame count.
//  6 arst_n pulsed low mid-payload -> all outputs at reset values next edge;
//    the next frame is framed correctly from crc init.

Source files
------------

// File: rtl/eth_tx_framer_pkg.sv
// Shared constants and state encodings for the Ethernet TX framer and RX FCS checker.
package eth_tx_framer_pkg;

    localparam logic [31:0] CRC32_POLY_R  = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam int ETH_MIN_LEN = 60;
    localparam int ETH_MAX_LEN = 1514;
    localparam int BYTE_CNT_W  = 11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DATA  = 3'd1,
        S_DRAIN = 3'd2,
        S_PAD   = 3'd3,
        S_FCS   = 3'd4
    } framer_state_e;

endpackage

// File: rtl/eth_tx_framer_crc.sv
// Combinational one-byte step of the reflected IEEE 802.3 CRC-32, LSB of the byte first.
module crc32_d8
    import eth_tx_framer_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  d,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) begin
                c = (c >> 1) ^ CRC32_POLY_R;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/my_bin2gray.sv
// Binary to Gray conversion, used so counters can be sampled safely from another clock domain.
module my_bin2gray #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/eth_tx_framer.sv
// Frames a raw byte stream for the RMII TX FIFO: zero-pads to MIN_LEN, truncates at MAX_LEN
// and appends the CRC-32 FCS, tagging the last FCS byte with EOD.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  S_IDLE  | waiting for the first byte (DA[0]) of a frame
//  S_DATA  | passing payload bytes through to the FIFO
//  S_DRAIN | frame hit MAX_LEN; discarding input up to in_last
//  S_PAD   | writing zero bytes until MIN_LEN is reached
//  S_FCS   | writing the four FCS bytes, EOD on the last
module eth_tx_framer
    import eth_tx_framer_pkg::*;
#(
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int MAX_LEN = ETH_MAX_LEN
) (
    input  logic        REF_CLK,
    input  logic        arst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    input  logic        fifo_afull,
    output logic        fifo_wren,
    output logic [7:0]  fifo_din,
    output logic        fifo_EOD_in,
    output logic [15:0] frame_count_gray,
    output logic [15:0] oversize_count_gray
);

    localparam logic [BYTE_CNT_W-1:0] MIN_CNT = BYTE_CNT_W'(MIN_LEN);
    localparam logic [BYTE_CNT_W-1:0] MAX_CNT = BYTE_CNT_W'(MAX_LEN);

    framer_state_e          state, state_nxt;
    logic [BYTE_CNT_W-1:0]  byte_cnt, byte_cnt_nxt, cnt_inc;
    logic [31:0]            crc, crc_nxt, crc_upd;
    logic [7:0]             crc_d, fcs_byte;
    logic                   stomp, stomp_nxt;
    logic [1:0]             fcs_idx, fcs_idx_nxt;
    logic                   run;
    logic                   accept;
    logic                   wren_nxt, eod_nxt;
    logic [7:0]             din_nxt;
    logic                   frame_inc, oversize_inc;
    logic [15:0]            frame_cnt, oversize_cnt;

    // run keeps in_ready low while reset is asserted and for the first edge after it
    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_IDLE, S_DATA: in_ready = run & ~fifo_afull;
            S_DRAIN:        in_ready = run;
            default:        in_ready = 1'b0;
        endcase
    end

    assign accept   = in_valid & in_ready;
    assign cnt_inc  = byte_cnt + BYTE_CNT_W'(1);
    assign crc_d    = (state == S_PAD) ? 8'h00 : in_data;
    assign fcs_byte = crc[{fcs_idx, 3'b000} +: 8];

    crc32_d8 u_crc32_d8 (
        .crc_in  (crc),
        .d       (crc_d),
        .crc_out (crc_upd)
    );

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        crc_nxt      = crc;
        stomp_nxt    = stomp;
        fcs_idx_nxt  = fcs_idx;
        wren_nxt     = 1'b0;
        din_nxt      = 8'h00;
        eod_nxt      = 1'b0;
        frame_inc    = 1'b0;
        oversize_inc = 1'b0;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    wren_nxt     = 1'b1;
                    din_nxt      = in_data;
                    crc_nxt      = crc_upd;
                    byte_cnt_nxt = BYTE_CNT_W'(1);
                    if (in_last) begin
                        state_nxt = (BYTE_CNT_W'(1) < MIN_CNT) ? S_PAD : S_FCS;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    wren_nxt     = 1'b1;
                    din_nxt      = in_data;
                    crc_nxt      = crc_upd;
                    byte_cnt_nxt = cnt_inc;
                    if (in_last) begin
                        state_nxt = (cnt_inc < MIN_CNT) ? S_PAD : S_FCS;
                    end else if (cnt_inc == MAX_CNT) begin
                        stomp_nxt    = 1'b1;
                        oversize_inc = 1'b1;
                        state_nxt    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (accept && in_last) begin
                    state_nxt = S_FCS;
                end
            end
            S_PAD: begin
                if (!fifo_afull) begin
                    wren_nxt     = 1'b1;
                    crc_nxt      = crc_upd;
                    byte_cnt_nxt = cnt_inc;
                    if (cnt_inc >= MIN_CNT) begin
                        state_nxt = S_FCS;
                    end
                end
            end
            S_FCS: begin
                if (!fifo_afull) begin
                    wren_nxt    = 1'b1;
                    // a stomped frame carries the raw crc, i.e. a deliberately wrong FCS
                    din_nxt     = stomp ? fcs_byte : ~fcs_byte;
                    fcs_idx_nxt = fcs_idx + 2'd1;
                    if (fcs_idx == 2'd3) begin
                        eod_nxt      = 1'b1;
                        frame_inc    = 1'b1;
                        crc_nxt      = CRC32_INIT;
                        byte_cnt_nxt = '0;
                        stomp_nxt    = 1'b0;
                        state_nxt    = S_IDLE;
                    end
                end
            end
            default: begin
                state_nxt    = S_IDLE;
                crc_nxt      = CRC32_INIT;
                byte_cnt_nxt = '0;
                stomp_nxt    = 1'b0;
                fcs_idx_nxt  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge REF_CLK or negedge arst_n) begin
        if (!arst_n) begin
            state        <= S_IDLE;
            byte_cnt     <= '0;
            crc          <= CRC32_INIT;
            stomp        <= 1'b0;
            fcs_idx      <= 2'd0;
            run          <= 1'b0;
            fifo_wren    <= 1'b0;
            fifo_din     <= 8'h00;
            fifo_EOD_in  <= 1'b0;
            frame_cnt    <= 16'h0000;
            oversize_cnt <= 16'h0000;
        end else begin
            state        <= state_nxt;
            byte_cnt     <= byte_cnt_nxt;
            crc          <= crc_nxt;
            stomp        <= stomp_nxt;
            fcs_idx      <= fcs_idx_nxt;
            run          <= 1'b1;
            fifo_wren    <= wren_nxt;
            fifo_din     <= din_nxt;
            fifo_EOD_in  <= eod_nxt;
            frame_cnt    <= frame_cnt + 16'(frame_inc);
            oversize_cnt <= oversize_cnt + 16'(oversize_inc);
        end
    end

    my_bin2gray #(.WIDTH(16)) u_frame_gray (
        .bin  (frame_cnt),
        .gray (frame_count_gray)
    );

    my_bin2gray #(.WIDTH(16)) u_oversize_gray (
        .bin  (oversize_cnt),
        .gray (oversize_count_gray)
    );

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: directed length table, randomized stalls, mid-frame reset.
module tb_eth_tx_framer;

    logic        REF_CLK = 1'b0;
    logic        arst_n;
    logic        in_valid, in_last, in_ready;
    logic [7:0]  in_data;
    logic        fifo_afull;
    logic        fifo_wren, fifo_EOD_in;
    logic [7:0]  fifo_din;
    logic [15:0] frame_count_gray, oversize_count_gray;

    logic [31:0] u_crc_in, u_crc_out;
    logic [7:0]  u_d;

    int tests = 0;
    int fails = 0;
    int eod_total = 0;
    int afull_pct = 0;
    int frames_done = 0;
    int over_done = 0;

    logic [7:0] tx_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] cap[$];

    typedef struct {
        int len;
        int exp_writes;
        int exp_pad;
        bit exp_stomp;
    } vec_t;
    vec_t vecs[9];

    always #10 REF_CLK = ~REF_CLK;

    eth_tx_framer dut (
        .REF_CLK             (REF_CLK),
        .arst_n              (arst_n),
        .in_valid            (in_valid),
        .in_data             (in_data),
        .in_last             (in_last),
        .in_ready            (in_ready),
        .fifo_afull          (fifo_afull),
        .fifo_wren           (fifo_wren),
        .fifo_din            (fifo_din),
        .fifo_EOD_in         (fifo_EOD_in),
        .frame_count_gray    (frame_count_gray),
        .oversize_count_gray (oversize_count_gray)
    );

    crc32_d8 u_crc_alone (
        .crc_in  (u_crc_in),
        .d       (u_d),
        .crc_out (u_crc_out)
    );

    always @(negedge REF_CLK) begin
        if (fifo_wren === 1'b1) begin
            cap.push_back({fifo_EOD_in, fifo_din});
            if (fifo_EOD_in === 1'b1) eod_total++;
        end
    end

    always @(negedge REF_CLK) begin
        fifo_afull = (afull_pct > 0) && ($urandom_range(99) < afull_pct);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] to_gray(input int n);
        logic [15:0] b;
        b = 16'(n);
        return b ^ (b >> 1);
    endfunction

    // bit-serial reflected CRC over the message stream
    function automatic logic [31:0] crc_step(input logic [31:0] c0, input logic [7:0] b);
        logic [31:0] c;
        logic fb;
        c = c0;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ b[i];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    function automatic void model_frame();
        int n, keep;
        bit st;
        logic [31:0] c;
        logic [7:0] body[$];
        logic [7:0] b;
        n    = tx_q.size();
        keep = (n > 1514) ? 1514 : n;
        st   = (n > 1514);
        c    = 32'hFFFFFFFF;
        for (int i = 0; i < keep; i++) body.push_back(tx_q[i]);
        while (body.size() < 60) body.push_back(8'h00);
        foreach (body[i]) begin
            c = crc_step(c, body[i]);
            exp_q.push_back({1'b0, body[i]});
        end
        for (int k = 0; k < 4; k++) begin
            b = c[8*k +: 8];
            exp_q.push_back({(k == 3), (st ? b : ~b)});
        end
        frames_done++;
        if (st) over_done++;
    endfunction

    task automatic fill_frame(input int len);
        tx_q.delete();
        for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
    endtask

    task automatic drive_frame(input int gap_pct);
        int i, waitc;
        logic rdy;
        i = 0;
        waitc = 0;
        while (i < tx_q.size()) begin
            @(negedge REF_CLK);
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = tx_q[i];
                in_last  = (i == tx_q.size() - 1);
            end
            #1;
            rdy = in_ready;
            @(posedge REF_CLK);
            if (in_valid && rdy) begin
                i++;
                waitc = 0;
            end else begin
                waitc++;
                if (waitc > 5000) begin
                    check("drive_timeout", 32'(i), 32'(tx_q.size()));
                    break;
                end
            end
        end
        @(negedge REF_CLK);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_eod(input int target);
        for (int c = 0; c < 8000; c++) begin
            @(posedge REF_CLK);
            if (eod_total >= target) break;
        end
        repeat (3) @(negedge REF_CLK);
        check("eod_total", 32'(eod_total), 32'(target));
    endtask

    function automatic int stream_mismatches();
        int m;
        m = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= cap.size() || cap[i] !== exp_q[i]) m++;
        end
        return m;
    endfunction

    initial begin
        logic [7:0] ascii[9];
        logic [31:0] c, r;
        int base, neod, npad;
        bit eod_last;

        arst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = 8'h00;
        fifo_afull = 1'b0;

        // crc unit on the standard check string
        ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 9; i++) begin
            u_crc_in = c;
            u_d = ascii[i];
            #1;
            c = u_crc_out;
        end
        check("crc32_check_string", ~c, 32'hCBF43926);

        #5;
        check("rst_wren", 32'(fifo_wren), 0);
        check("rst_din", 32'(fifo_din), 0);
        check("rst_eod", 32'(fifo_EOD_in), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_frame_cnt", 32'(frame_count_gray), 0);
        check("rst_over_cnt", 32'(oversize_count_gray), 0);
        @(negedge REF_CLK);
        arst_n = 1'b1;
        repeat (2) @(negedge REF_CLK);

        vecs[0] = '{len: 1,    exp_writes: 64,   exp_pad: 59, exp_stomp: 1'b0};
        vecs[1] = '{len: 14,   exp_writes: 64,   exp_pad: 46, exp_stomp: 1'b0};
        vecs[2] = '{len: 59,   exp_writes: 64,   exp_pad: 1,  exp_stomp: 1'b0};
        vecs[3] = '{len: 60,   exp_writes: 64,   exp_pad: 0,  exp_stomp: 1'b0};
        vecs[4] = '{len: 61,   exp_writes: 65,   exp_pad: 0,  exp_stomp: 1'b0};
        vecs[5] = '{len: 1513, exp_writes: 1517, exp_pad: 0,  exp_stomp: 1'b0};
        vecs[6] = '{len: 1514, exp_writes: 1518, exp_pad: 0,  exp_stomp: 1'b0};
        vecs[7] = '{len: 1515, exp_writes: 1518, exp_pad: 0,  exp_stomp: 1'b1};
        vecs[8] = '{len: 1600, exp_writes: 1518, exp_pad: 0,  exp_stomp: 1'b1};

        foreach (vecs[v]) begin
            cap.delete();
            exp_q.delete();
            base = eod_total;
            fill_frame(vecs[v].len);
            model_frame();
            drive_frame(0);
            wait_eod(base + 1);
            check($sformatf("writes_len%0d", vecs[v].len), 32'(cap.size()), 32'(vecs[v].exp_writes));
            npad = cap.size() - 4 - ((vecs[v].len > 1514) ? 1514 : vecs[v].len);
            check($sformatf("pad_len%0d", vecs[v].len), 32'(npad), 32'(vecs[v].exp_pad));
            check($sformatf("stream_len%0d", vecs[v].len), 32'(stream_mismatches()), 0);
            neod = 0;
            foreach (cap[i]) if (cap[i][8]) neod++;
            eod_last = (cap.size() > 0) ? cap[cap.size()-1][8] : 1'b0;
            check($sformatf("eod_count_len%0d", vecs[v].len), 32'(neod), 1);
            check($sformatf("eod_last_len%0d", vecs[v].len), 32'(eod_last), 1);
            r = 32'hFFFFFFFF;
            foreach (cap[i]) r = crc_step(r, cap[i][7:0]);
            check($sformatf("residue_len%0d", vecs[v].len), 32'(r != 32'hDEBB20E3), 32'(vecs[v].exp_stomp));
            check($sformatf("frame_gray_len%0d", vecs[v].len), 32'(frame_count_gray), 32'(to_gray(frames_done)));
            check($sformatf("over_gray_len%0d", vecs[v].len), 32'(oversize_count_gray), 32'(to_gray(over_done)));
        end

        // back-to-back frames with FIFO backpressure and source gaps
        cap.delete();
        exp_q.delete();
        base = eod_total;
        afull_pct = 30;
        for (int f = 0; f < 10; f++) begin
            fill_frame((f == 0) ? 75 : $urandom_range(1, 120));
            model_frame();
            drive_frame(25);
        end
        wait_eod(base + 10);
        afull_pct = 0;
        check("stall_writes", 32'(cap.size()), 32'(exp_q.size()));
        check("stall_stream", 32'(stream_mismatches()), 0);
        neod = 0;
        foreach (cap[i]) if (cap[i][8]) neod++;
        check("stall_eod_count", 32'(neod), 10);
        check("stall_frame_gray", 32'(frame_count_gray), 32'(to_gray(frames_done)));

        // reset in the middle of a payload
        for (int i = 0; i < 20; i++) begin
            @(negedge REF_CLK);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'b0;
        end
        @(negedge REF_CLK);
        in_valid = 1'b0;
        arst_n = 1'b0;
        @(posedge REF_CLK);
        #1;
        check("midrst_wren", 32'(fifo_wren), 0);
        check("midrst_din", 32'(fifo_din), 0);
        check("midrst_eod", 32'(fifo_EOD_in), 0);
        check("midrst_in_ready", 32'(in_ready), 0);
        check("midrst_frame_cnt", 32'(frame_count_gray), 0);
        check("midrst_over_cnt", 32'(oversize_count_gray), 0);
        @(negedge REF_CLK);
        arst_n = 1'b1;
        frames_done = 0;
        over_done = 0;
        cap.delete();
        exp_q.delete();
        base = eod_total;
        fill_frame(30);
        model_frame();
        drive_frame(0);
        wait_eod(base + 1);
        check("postrst_writes", 32'(cap.size()), 64);
        check("postrst_stream", 32'(stream_mismatches()), 0);
        check("postrst_frame_gray", 32'(frame_count_gray), 32'(to_gray(1)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
